// File: rtl/read_response_channel_pkg.sv
// Shared types for the read response channel: R-channel response codes and the
// registered output beat.
package read_response_channel_pkg;

  localparam int R_DATA_W = 64;
  localparam int R_TID_W  = 2;
  localparam int R_LEN_W  = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } rresp_t;

  typedef struct packed {
    logic [R_DATA_W-1:0] data;
    logic [R_TID_W-1:0]  tid;
    logic                last;
    rresp_t              resp;
  } r_beat_t;

endpackage

// File: rtl/read_response_channel_tid_len_table.sv
// Per-TID burst table: armed flag, burst length (beats-1) and beat counter.
// Lookups are combinational; arm and pop updates land on the same clock edge.
module tid_len_table
  import read_response_channel_pkg::*;
#(
  parameter int TID_SIZE = R_TID_W,
  parameter int LEN_SIZE = R_LEN_W
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                arm_en,
  input  logic [TID_SIZE-1:0] arm_tid,
  input  logic [LEN_SIZE-1:0] arm_len,
  input  logic                pop_en,
  input  logic [TID_SIZE-1:0] pop_tid,
  output logic                pop_armed,
  output logic                pop_last,
  output logic                arm_busy,
  output logic                any_armed
);

  localparam int DEPTH = 2 ** TID_SIZE;

  logic [DEPTH-1:0]    armed_r;
  logic [LEN_SIZE-1:0] len_r [DEPTH];
  logic [LEN_SIZE-1:0] cnt_r [DEPTH];

  // Table update; arm never targets an armed entry, so it cannot clash with a pop
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      armed_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        len_r[i] <= '0;
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (arm_en && (arm_tid == TID_SIZE'(i))) begin
          armed_r[i] <= 1'b1;
          len_r[i]   <= arm_len;
          cnt_r[i]   <= '0;
        end else if (pop_en && pop_armed && (pop_tid == TID_SIZE'(i))) begin
          if (pop_last) begin
            armed_r[i] <= 1'b0;
            cnt_r[i]   <= '0;
          end else begin
            cnt_r[i]   <= cnt_r[i] + LEN_SIZE'(1);
          end
        end
      end
    end
  end

  assign pop_armed = armed_r[pop_tid];
  assign pop_last  = (cnt_r[pop_tid] == len_r[pop_tid]);
  assign arm_busy  = armed_r[arm_tid];
  assign any_armed = |armed_r;

endmodule

// File: rtl/read_response_channel.sv
// R-channel driver: pops ordered beats from the read data buffer into a single
// registered output stage, tagging rlast/rresp from the per-TID burst table.
module read_response_channel
  import read_response_channel_pkg::*;
#(
  parameter int DATA_SIZE = R_DATA_W,
  parameter int TID_SIZE  = R_TID_W,
  parameter int LEN_SIZE  = R_LEN_W
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 arm_valid,
  input  logic [TID_SIZE-1:0]  arm_tid,
  input  logic [LEN_SIZE-1:0]  arm_len,
  output logic                 arm_ready,
  input  logic                 buf_rvalid,
  input  logic [DATA_SIZE-1:0] buf_rdata,
  input  logic [TID_SIZE-1:0]  buf_tid,
  output logic                 buf_ren,
  output logic                 m_rvalid,
  output logic [DATA_SIZE-1:0] m_rdata,
  output logic [TID_SIZE-1:0]  m_rid,
  output logic                 m_rlast,
  output logic [1:0]           m_rresp,
  input  logic                 m_rready,
  output logic                 busy,
  output logic                 err_orphan
);

  logic    pop_s;
  logic    arm_en_s;
  logic    pop_armed_s;
  logic    pop_last_s;
  logic    arm_busy_s;
  logic    any_armed_s;
  r_beat_t beat_next_s;
  r_beat_t beat_r;
  logic    valid_r;
  logic    orphan_r;

  // Pop only when the output stage is empty or is being drained this cycle
  assign pop_s     = buf_rvalid && (!valid_r || m_rready);
  assign arm_en_s  = arm_valid && !arm_busy_s;
  assign arm_ready = !arm_busy_s;
  assign buf_ren   = pop_s;

  tid_len_table #(
    .TID_SIZE (TID_SIZE),
    .LEN_SIZE (LEN_SIZE)
  ) u_table (
    .clk       (clk),
    .n_rst     (n_rst),
    .arm_en    (arm_en_s),
    .arm_tid   (arm_tid),
    .arm_len   (arm_len),
    .pop_en    (pop_s),
    .pop_tid   (buf_tid),
    .pop_armed (pop_armed_s),
    .pop_last  (pop_last_s),
    .arm_busy  (arm_busy_s),
    .any_armed (any_armed_s)
  );

  // Build the next output beat; unarmed TIDs close as a single SLVERR beat
  always_comb begin
    beat_next_s      = '0;
    beat_next_s.data = buf_rdata;
    beat_next_s.tid  = buf_tid;
    if (pop_armed_s) begin
      beat_next_s.last = pop_last_s;
      beat_next_s.resp = RESP_OKAY;
    end else begin
      beat_next_s.last = 1'b1;
      beat_next_s.resp = RESP_SLVERR;
    end
  end

  // Output stage: load on pop, clear valid on accept, otherwise hold
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      beat_r  <= '0;
      valid_r <= 1'b0;
    end else if (pop_s) begin
      beat_r  <= beat_next_s;
      valid_r <= 1'b1;
    end else if (m_rready) begin
      valid_r <= 1'b0;
    end
  end

  // Sticky orphan-beat flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      orphan_r <= 1'b0;
    end else if (pop_s && !pop_armed_s) begin
      orphan_r <= 1'b1;
    end
  end

  assign m_rvalid   = valid_r;
  assign m_rdata    = beat_r.data;
  assign m_rid      = beat_r.tid;
  assign m_rlast    = beat_r.last;
  assign m_rresp    = beat_r.resp;
  assign busy       = any_armed_s || valid_r;
  assign err_orphan = orphan_r;

endmodule

// File: tb/tb_read_response_channel.sv
// Bench for read_response_channel: directed table, hand-written corner sequences
// and randomized traffic, all checked against a burst-level reference model.
module tb_read_response_channel;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        arm_valid;
  logic [1:0]  arm_tid;
  logic [7:0]  arm_len;
  logic        arm_ready;
  logic        buf_rvalid;
  logic [63:0] buf_rdata;
  logic [1:0]  buf_tid;
  logic        buf_ren;
  logic        m_rvalid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rid;
  logic        m_rlast;
  logic [1:0]  m_rresp;
  logic        m_rready;
  logic        busy;
  logic        err_orphan;

  always #5 clk = ~clk;

  read_response_channel dut (
    .clk(clk), .n_rst(n_rst),
    .arm_valid(arm_valid), .arm_tid(arm_tid), .arm_len(arm_len), .arm_ready(arm_ready),
    .buf_rvalid(buf_rvalid), .buf_rdata(buf_rdata), .buf_tid(buf_tid), .buf_ren(buf_ren),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast),
    .m_rresp(m_rresp), .m_rready(m_rready), .busy(busy), .err_orphan(err_orphan)
  );

  typedef struct { logic [63:0] data; logic [1:0] tid; } beat_t;
  typedef struct {
    bit av; logic [1:0] at; logic [7:0] al; bit pu; logic [1:0] pt; bit rr;
    bit ev; logic [1:0] eid; bit el; logic [1:0] er; bit eb;
  } vec_t;

  beat_t       bq[$];
  logic [63:0] acc_data[$];
  vec_t        vt[$];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] dctr = 64'hD0;

  // Reference model: burst state as beats remaining, plus the expected output beat
  bit          m_armed [4];
  int          m_rem   [4];
  bit          mv, ml, mo;
  logic [63:0] md;
  logic [1:0]  mt, mr;
  bit          s_ren, s_ardy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] t);
    bq.push_back('{data: dctr, tid: t});
    dctr = dctr + 64'd1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_armed[i] = 1'b0;
      m_rem[i]   = 0;
    end
    mv = 1'b0; ml = 1'b0; mo = 1'b0; md = '0; mt = '0; mr = '0;
    bq.delete();
  endtask

  function automatic bit any_armed();
    return m_armed[0] | m_armed[1] | m_armed[2] | m_armed[3];
  endfunction

  // One clock: entered and left at the falling edge
  task automatic cycle();
    bit    pop, acc, armh;
    beat_t b;
    buf_rvalid = (bq.size() != 0);
    if (buf_rvalid) begin
      buf_rdata = bq[0].data;
      buf_tid   = bq[0].tid;
    end else begin
      buf_rdata = '0;
      buf_tid   = '0;
    end
    #1;
    pop  = buf_rvalid && (!mv || m_rready);
    acc  = mv && m_rready;
    armh = arm_valid && !m_armed[arm_tid];
    chk("buf_ren", buf_ren, pop);
    chk("arm_ready", arm_ready, !m_armed[arm_tid]);
    s_ren  = buf_ren;
    s_ardy = arm_ready;
    if (m_rvalid && m_rready) acc_data.push_back(m_rdata);
    @(posedge clk);
    #1;
    if (pop) begin
      b  = bq.pop_front();
      md = b.data;
      mt = b.tid;
      mv = 1'b1;
      if (m_armed[b.tid]) begin
        ml = (m_rem[b.tid] == 1);
        mr = 2'b00;
        m_rem[b.tid] = m_rem[b.tid] - 1;
        if (ml) m_armed[b.tid] = 1'b0;
      end else begin
        ml = 1'b1;
        mr = 2'b10;
        mo = 1'b1;
      end
    end else if (acc) begin
      mv = 1'b0;
    end
    if (armh) begin
      m_armed[arm_tid] = 1'b1;
      m_rem[arm_tid]   = int'(arm_len) + 1;
    end
    chk("m_rvalid", m_rvalid, mv);
    if (mv) begin
      chk("m_rdata", m_rdata, md);
      chk("m_rid", m_rid, mt);
      chk("m_rlast", m_rlast, ml);
      chk("m_rresp", m_rresp, mr);
    end
    chk("busy", busy, any_armed() || mv);
    chk("err_orphan", err_orphan, mo);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] base;
    n_rst = 1'b0; arm_valid = 1'b0; arm_tid = '0; arm_len = '0;
    buf_rvalid = 1'b0; buf_rdata = '0; buf_tid = '0; m_rready = 1'b0;
    model_reset();
    #2;
    chk("rst_m_rvalid", m_rvalid, 1'b0);
    chk("rst_m_rdata", m_rdata, 64'd0);
    chk("rst_m_rid", m_rid, 2'd0);
    chk("rst_m_rlast", m_rlast, 1'b0);
    chk("rst_m_rresp", m_rresp, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_orphan", err_orphan, 1'b0);
    chk("rst_buf_ren", buf_ren, 1'b0);
    chk("rst_arm_ready", arm_ready, 1'b1);
    @(negedge clk);
    n_rst = 1'b1;

    // Directed table: single burst, interleaved TIDs, orphan beat
    vt.push_back('{1'b1, 2'd1, 8'd3, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0});
    vt.push_back('{1'b1, 2'd0, 8'd1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1});
    vt.push_back('{1'b1, 2'd2, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 2'd0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b1, 2'd3, 1'b1, 1'b1, 2'd3, 1'b1, 2'd2, 1'b1});
    vt.push_back('{1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0});
    for (int i = 0; i < vt.size(); i++) begin
      arm_valid = vt[i].av; arm_tid = vt[i].at; arm_len = vt[i].al;
      if (vt[i].pu) push(vt[i].pt);
      m_rready = vt[i].rr;
      cycle();
      chk($sformatf("vec%0d_rvalid", i), m_rvalid, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_rid", i), m_rid, vt[i].eid);
        chk($sformatf("vec%0d_rlast", i), m_rlast, vt[i].el);
        chk($sformatf("vec%0d_rresp", i), m_rresp, vt[i].er);
      end
      chk($sformatf("vec%0d_busy", i), busy, vt[i].eb);
    end
    chk("orphan_sticky", err_orphan, 1'b1);
    arm_valid = 1'b0;

    // Backpressure on beat 2 of a 4-beat burst
    arm_valid = 1'b1; arm_tid = 2'd1; arm_len = 8'd3; m_rready = 1'b1;
    cycle();
    arm_valid = 1'b0;
    base = dctr;
    for (int k = 0; k < 4; k++) push(2'd1);
    acc_data.delete();
    cycle();
    cycle();
    chk("bp_beat2", m_rdata, base + 64'd1);
    m_rready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_rdata", m_rdata, base + 64'd1);
      chk("bp_hold_rlast", m_rlast, 1'b0);
      chk("bp_hold_ren", s_ren, 1'b0);
    end
    m_rready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    chk("bp_count", acc_data.size(), 4);
    for (int k = 0; k < acc_data.size(); k++)
      chk("bp_order", acc_data[k], base + 64'(k));
    chk("bp_busy_after", busy, 1'b0);

    // Arm while armed stalls until the burst closes; re-arm with len 0
    arm_valid = 1'b1; arm_tid = 2'd1; arm_len = 8'd1;
    cycle();
    arm_len = 8'd0;
    push(2'd1); push(2'd1);
    cycle();
    chk("rearm_stall_a", s_ardy, 1'b0);
    cycle();
    chk("rearm_stall_b", s_ardy, 1'b0);
    cycle();
    chk("rearm_ready", s_ardy, 1'b1);
    arm_valid = 1'b0;
    push(2'd1);
    cycle();
    chk("rearm_len0_rlast", m_rlast, 1'b1);
    chk("rearm_len0_rresp", m_rresp, 2'b00);
    cycle();

    // Reset in the middle of a burst
    arm_valid = 1'b1; arm_tid = 2'd1; arm_len = 8'd3;
    cycle();
    arm_valid = 1'b0;
    for (int k = 0; k < 4; k++) push(2'd1);
    cycle();
    cycle();
    #2;
    n_rst = 1'b0;
    bq.delete();
    buf_rvalid = 1'b0;
    #1;
    chk("mrst_m_rvalid", m_rvalid, 1'b0);
    chk("mrst_m_rdata", m_rdata, 64'd0);
    chk("mrst_m_rid", m_rid, 2'd0);
    chk("mrst_m_rlast", m_rlast, 1'b0);
    chk("mrst_m_rresp", m_rresp, 2'd0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_err_orphan", err_orphan, 1'b0);
    chk("mrst_buf_ren", buf_ren, 1'b0);
    chk("mrst_arm_ready", arm_ready, 1'b1);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    arm_valid = 1'b1; arm_tid = 2'd1; arm_len = 8'd1;
    cycle();
    arm_valid = 1'b0;
    push(2'd1); push(2'd1);
    cycle();
    chk("post_rst_b1_rlast", m_rlast, 1'b0);
    cycle();
    chk("post_rst_b2_rlast", m_rlast, 1'b1);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] t;
      arm_valid = ($urandom_range(0, 3) == 0);
      arm_tid   = 2'($urandom_range(0, 3));
      arm_len   = 8'($urandom_range(0, 4));
      if (bq.size() < 6 && $urandom_range(0, 1) == 1) begin
        t = 2'($urandom_range(0, 3));
        for (int k = 0; k < 4 && !m_armed[t] && $urandom_range(0, 9) != 0; k++)
          t = 2'($urandom_range(0, 3));
        bq.push_back('{data: {$urandom, $urandom}, tid: t});
      end
      m_rready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
